// File: rtl/stream_fifo.sv
// stream_fifo: synchronous first-word-fall-through byte FIFO with
// valid/ready handshakes on both sides. Sits between uart_rx and its
// consumer to absorb bursts while the transmitter is still busy.
// Pointers carry one extra MSB so full and empty can be told apart
// without a separate occupancy counter.

module stream_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [AW:0]   level,
  output logic          overflow
);

  // Reject depths that are not a power of two or are smaller than 2.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("stream_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [W-1:0] mem_r [DEPTH];
  logic [AW:0]  wp_r;
  logic [AW:0]  rp_r;
  logic         overflow_r;

  logic         empty_s;
  logic         full_s;
  logic         push_s;
  logic         pop_s;

  // Status and handshake decode, driven only by the registered pointers
  // so in_ready/out_valid never depend on the partner's valid/ready.
  always_comb begin
    empty_s = (wp_r == rp_r);
    full_s  = (wp_r[AW-1:0] == rp_r[AW-1:0]) && (wp_r[AW] != rp_r[AW]);
    push_s  = 1'b0;
    pop_s   = 1'b0;
    if (in_valid && !full_s) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if (out_ready && !empty_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Output drive: head entry falls through asynchronously; occupancy is
  // the modular pointer difference.
  always_comb begin
    in_ready  = !full_s;
    out_valid = !empty_s;
    out_data  = mem_r[rp_r[AW-1:0]];
    level     = wp_r - rp_r;
    overflow  = overflow_r;
  end

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wp_r[AW-1:0]] <= in_data;
    end
  end

  // Pointer advance; wrap at 2^(AW+1) happens naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_r <= {(AW+1){1'b0}};
      rp_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wp_r <= wp_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rp_r <= rp_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Sticky overflow: producer offered data while the FIFO was full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r <= 1'b0;
    end else if (in_valid && full_s) begin
      overflow_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: a vector table for the basic
// push/drain sequence plus hand-written multi-cycle corner cases and a
// randomized run against a reference queue.

module tb_stream_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [AW:0]   level;
  logic          overflow;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        iv;
    logic [7:0]  d;
    logic        ordy;
    logic [4:0]  lvl;
    logic        ov;
    logic        ir;
    logic [7:0]  od;
    logic        odc;
  } vec_t;

  vec_t vt [12];
  logic [7:0] q [$];

  always #5 clk = ~clk;

  stream_fifo #(.W(W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .level    (level),
    .overflow (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs just after the falling edge; outputs are then sampled
  // mid-low-phase, well away from the rising edge.
  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  initial begin
    logic iv_r;
    logic ordy_r;
    logic do_push;
    logic do_pop;
    int   thr;

    // iv d ordy | level ov ir od odc
    vt[0]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 8'h00, 1'b0};
    vt[1]  = '{1'b1, 8'h01, 1'b0, 5'd0, 1'b0, 1'b1, 8'h00, 1'b0};
    vt[2]  = '{1'b1, 8'h02, 1'b0, 5'd1, 1'b1, 1'b1, 8'h01, 1'b1};
    vt[3]  = '{1'b1, 8'h03, 1'b0, 5'd2, 1'b1, 1'b1, 8'h01, 1'b1};
    vt[4]  = '{1'b1, 8'h04, 1'b0, 5'd3, 1'b1, 1'b1, 8'h01, 1'b1};
    vt[5]  = '{1'b1, 8'h05, 1'b0, 5'd4, 1'b1, 1'b1, 8'h01, 1'b1};
    vt[6]  = '{1'b0, 8'h00, 1'b1, 5'd5, 1'b1, 1'b1, 8'h01, 1'b1};
    vt[7]  = '{1'b0, 8'h00, 1'b1, 5'd4, 1'b1, 1'b1, 8'h02, 1'b1};
    vt[8]  = '{1'b0, 8'h00, 1'b1, 5'd3, 1'b1, 1'b1, 8'h03, 1'b1};
    vt[9]  = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b1, 1'b1, 8'h04, 1'b1};
    vt[10] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b1, 1'b1, 8'h05, 1'b1};
    vt[11] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 8'h00, 1'b0};

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset/idle, push 0x01..0x05, then drain in order.
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].iv, vt[i].d, vt[i].ordy);
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(vt[i].lvl));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vt[i].ov));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vt[i].ir));
      chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'd0);
      if (vt[i].odc) chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vt[i].od));
    end

    // Fill to DEPTH with 0x10..0x1F.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 8'(8'h10 + i), 1'b0);
      chk("fill_level", 32'(level), 32'(i));
      chk("fill_in_ready", 32'(in_ready), 32'd1);
    end
    // Offer 0xAA while full: blocked and flagged.
    drive(1'b1, 8'hAA, 1'b0);
    chk("full_level", 32'(level), 32'd16);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_overflow_pre", 32'(overflow), 32'd0);
    drive(1'b1, 8'hAA, 1'b0);
    chk("full_overflow_set", 32'(overflow), 32'd1);
    chk("full_level_hold", 32'(level), 32'd16);
    // Drain: 0x10..0x1F, no 0xAA.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      chk("drain_out_valid", 32'(out_valid), 32'd1);
      chk("drain_out_data", 32'(out_data), 32'(8'h10 + i));
      chk("drain_level", 32'(level), 32'(DEPTH - i));
    end
    drive(1'b0, 8'h00, 1'b0);
    chk("drained_out_valid", 32'(out_valid), 32'd0);
    chk("drained_level", 32'(level), 32'd0);
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // Continuous push+pop for 40 cycles across the pointer wrap.
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      if (i == 0) begin
        chk("stream_first_level", 32'(level), 32'd0);
        chk("stream_first_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("stream_level", 32'(level), 32'd1);
        chk("stream_out_data", 32'(out_data), 32'(i - 1));
      end
    end
    drive(1'b0, 8'h00, 1'b1);
    chk("stream_last_data", 32'(out_data), 32'h27);
    chk("stream_last_level", 32'(level), 32'd1);
    drive(1'b0, 8'h00, 1'b0);
    chk("stream_empty_level", 32'(level), 32'd0);

    // Mid-burst asynchronous reset at level 7.
    for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h60 + i), 1'b0);
    drive(1'b1, 8'h67, 1'b0);
    chk("pre_reset_level", 32'(level), 32'd7);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_level", 32'(level), 32'd0);
    chk("async_rst_overflow", 32'(overflow), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 8'h55, 1'b0);
    chk("post_rst_empty", 32'(out_valid), 32'd0);
    drive(1'b0, 8'h00, 1'b0);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data", 32'(out_data), 32'h55);
    chk("post_rst_level", 32'(level), 32'd1);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    chk("post_rst_drained", 32'(level), 32'd0);

    // Randomized traffic against a reference queue, producer honours ready.
    q.delete();
    for (int i = 0; i < 10000; i++) begin
      thr    = ((i / 1000) % 2 == 0) ? 3 : 1;
      iv_r   = ($urandom_range(0, 3) < 32'(thr)) && (q.size() < DEPTH);
      ordy_r = ($urandom_range(0, 3) >= 32'(thr));
      drive(iv_r, 8'($urandom_range(0, 255)), ordy_r);
      chk("rand_level", 32'(level), 32'(q.size()));
      chk("rand_out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("rand_in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      if (q.size() != 0) chk("rand_out_data", 32'(out_data), 32'(q[0]));
      do_push = iv_r && (q.size() < DEPTH);
      do_pop  = ordy_r && (q.size() != 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(in_data);
    end
    drive(1'b0, 8'h00, 1'b0);
    chk("rand_overflow", 32'(overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
